hgw_icg_ctrl: RTL and testbench
===============================

HGW_ICG_CTRL -- requirements
Module: hgw_icg_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the idle counter and of idle_thresh_i.
REQ-002 SHALL have parameter WAKE_CYC, default 2, number of cycles hw_en_o is held high after wake before gating may restart (legal range 1..255).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_i  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port auto_en_i  input  1  hardware auto-gating enable.
REQ-007 SHALL have port busy_i  input  1  activity indication from the gated domain, level.
REQ-008 SHALL have port wake_req_i  input  1  external wake request, level or pulse.
REQ-009 SHALL have port idle_thresh_i  input  CNT_W  idle cycles required before requesting gating; 0 disables gating.
REQ-010 SHALL have port gate_ack_i  input  1  gated-domain agreement to stop clock.
REQ-011 SHALL have port gate_req_o  output  1  request to stop clock.
REQ-012 SHALL have port hw_en_o  output  1  clock enable, drives hw_en of hgw_icg (HW_EN_ASYNC=0).
REQ-013 SHALL have port gated_o  output  1  status, clock currently gated.

Function
REQ-014 SHALL implement FSM states RUN, COUNT, REQ, GATED, WAKE; all outputs registered, decoded from next state.
REQ-015 SHALL drive hw_en_o=0 only in GATED, gate_req_o=1 only in REQ, gated_o=1 only in GATED.
REQ-016 RUN: if auto_en_i=1, busy_i=0, wake_req_i=0, idle_thresh_i!=0 -> COUNT with cnt=1; else stay.
REQ-017 COUNT: busy_i=1, wake_req_i=1 or auto_en_i=0 -> RUN, cnt cleared; else cnt>=idle_thresh_i -> REQ; else cnt+1 (no wrap, compare precedes increment).
REQ-018 COUNT: idle_thresh_i changing mid-count SHALL take effect on the next compare; change to 0 -> RUN.
REQ-019 REQ: busy_i, wake_req_i or auto_en_i=0 -> RUN (abort, gate_req_o drops next cycle) with priority over gate_ack_i; else gate_ack_i=1 -> GATED.
REQ-020 GATED: busy_i, wake_req_i or auto_en_i=0 -> WAKE with wake counter cleared; gate_ack_i ignored.
REQ-021 WAKE: hw_en_o=1; after exactly WAKE_CYC cycles in WAKE -> RUN regardless of inputs.
REQ-022 gate_ack_i outside REQ SHALL be ignored.
REQ-023 Latency: gate_ack_i sampled high at edge N (in REQ) -> hw_en_o low after edge N; wake sampled at edge M (in GATED) -> hw_en_o high after edge M.
REQ-024 Minimum idle: from busy_i last sampled high to gate_req_o rising SHALL be idle_thresh_i+1 cycles.

Reset
REQ-025 rst_i=1 at an edge SHALL force state RUN, cnt=0, wake counter=0, hw_en_o=1, gate_req_o=0, gated_o=0, overriding any state including GATED and REQ.

Structure
REQ-026 State encoding typedef and WAKE_CYC/CNT_W defaults SHALL live in shared package hgw_icg_pkg.
REQ-027 No sub-module; instantiated alongside hgw_icg, which it does not contain.

Verification
REQ-028 thresh=4, busy falls, ack after 3 cycles in REQ -> gate_req_o high 5 cycles after busy low, hw_en_o low the cycle after ack sample, gated_o=1.
REQ-029 In REQ, busy_i and gate_ack_i high same edge -> RUN, hw_en_o stays 1, gate_req_o low next cycle.
REQ-030 GATED, wake_req_i 1-cycle pulse, WAKE_CYC=2 -> hw_en_o high next cycle, RUN after 2 cycles, no gating for >= thresh+1 further cycles.
REQ-031 idle_thresh_i=0 with busy_i=0 for 1000 cycles -> gate_req_o never asserts, hw_en_o=1.
REQ-032 rst_i asserted in GATED -> next cycle hw_en_o=1, gated_o=0, gate_req_o=0.
REQ-033 auto_en_i dropped in COUNT at cnt=3 (thresh=8) -> RUN, next idle period restarts count from 1.

Source files
------------

// File: rtl/hgw_icg_pkg.sv
// Shared types and defaults for the hardware clock-gating controller.
// The state encoding and parameter defaults live here so testbenches and siblings agree.
package hgw_icg_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_COUNT = 3'd1,
        ST_REQ   = 3'd2,
        ST_GATED = 3'd3,
        ST_WAKE  = 3'd4
    } state_e;

    localparam int CNT_W_DEF    = 8;
    localparam int WAKE_CYC_DEF = 2;
    localparam int WCNT_W       = 8;

    // Any of these conditions means the gated domain must keep (or regain) its clock.
    function automatic logic need_clk(input logic busy, input logic wake, input logic auto_en);
        return busy | wake | ~auto_en;
    endfunction

endpackage

// File: rtl/hgw_icg_ctrl.sv
// Idle-driven clock-gating controller: counts idle cycles, handshakes a gate request,
// and holds the clock enable high for a fixed wake window after un-gating.
module hgw_icg_ctrl
    import hgw_icg_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int WAKE_CYC = WAKE_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             auto_en_i,
    input  logic             busy_i,
    input  logic             wake_req_i,
    input  logic [CNT_W-1:0] idle_thresh_i,
    input  logic             gate_ack_i,
    output logic             gate_req_o,
    output logic             hw_en_o,
    output logic             gated_o
);

    state_e              state_r;
    state_e              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic [WCNT_W-1:0]   wcnt_r;
    logic [WCNT_W-1:0]   wcnt_s;
    logic                gate_req_r;
    logic                hw_en_r;
    logic                gated_r;
    logic                need_clk_s;
    logic                thresh_zero_s;

    assign need_clk_s    = need_clk(busy_i, wake_req_i, auto_en_i);
    assign thresh_zero_s = (idle_thresh_i == {CNT_W{1'b0}});

    // Next-state, idle counter and wake counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        wcnt_s  = wcnt_r;
        case (state_r)
            ST_RUN: begin
                if (!need_clk_s && !thresh_zero_s) begin
                    state_s = ST_COUNT;
                    cnt_s   = CNT_W'(1);
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            ST_COUNT: begin
                // Threshold is re-read on every compare, so a live change applies immediately.
                if (need_clk_s || thresh_zero_s) begin
                    state_s = ST_RUN;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r >= idle_thresh_i) begin
                    state_s = ST_REQ;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s   = cnt_r;
                end
            end
            ST_REQ: begin
                if (need_clk_s) begin
                    state_s = ST_RUN;
                end else if (gate_ack_i) begin
                    state_s = ST_GATED;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_GATED: begin
                if (need_clk_s) begin
                    state_s = ST_WAKE;
                    wcnt_s  = {WCNT_W{1'b0}};
                end else begin
                    state_s = ST_GATED;
                end
            end
            ST_WAKE: begin
                // wcnt_r counts completed WAKE cycles; leave on the WAKE_CYC-th edge.
                if (wcnt_r >= WCNT_W'(WAKE_CYC - 1)) begin
                    state_s = ST_RUN;
                    wcnt_s  = {WCNT_W{1'b0}};
                end else begin
                    wcnt_s  = wcnt_r + WCNT_W'(1);
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = {CNT_W{1'b0}};
                wcnt_s  = {WCNT_W{1'b0}};
            end
        endcase
    end

    // State, counters and outputs registered; outputs decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_RUN;
            cnt_r      <= {CNT_W{1'b0}};
            wcnt_r     <= {WCNT_W{1'b0}};
            gate_req_r <= 1'b0;
            hw_en_r    <= 1'b1;
            gated_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            wcnt_r     <= wcnt_s;
            gate_req_r <= (state_s == ST_REQ);
            hw_en_r    <= (state_s != ST_GATED);
            gated_r    <= (state_s == ST_GATED);
        end
    end

    assign gate_req_o = gate_req_r;
    assign hw_en_o    = hw_en_r;
    assign gated_o    = gated_r;

endmodule

// File: tb/tb_hgw_icg_ctrl.sv
// Directed scoreboard bench for hgw_icg_ctrl: each step queues the expected
// {gate_req, hw_en, gated} and checks it one edge later.
module tb_hgw_icg_ctrl;

    localparam int CNT_W = 8;

    localparam logic [2:0] E_RUN = 3'b010;
    localparam logic [2:0] E_REQ = 3'b110;
    localparam logic [2:0] E_GAT = 3'b001;

    typedef struct {
        logic [2:0] exp;
        string      tag;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             auto_en;
    logic             busy;
    logic             wake;
    logic [CNT_W-1:0] thresh;
    logic             ack;
    logic             gate_req;
    logic             hw_en;
    logic             gated;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    hgw_icg_ctrl #(.CNT_W(CNT_W), .WAKE_CYC(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .auto_en_i     (auto_en),
        .busy_i        (busy),
        .wake_req_i    (wake),
        .idle_thresh_i (thresh),
        .gate_ack_i    (ack),
        .gate_req_o    (gate_req),
        .hw_en_o       (hw_en),
        .gated_o       (gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic b, input logic w, input logic a,
                       input logic [2:0] e, input string tag);
        exp_t it;
        logic [2:0] obs;
        @(negedge clk);
        busy = b;
        wake = w;
        ack  = a;
        it.exp = e;
        it.tag = tag;
        sb.push_back(it);
        @(posedge clk);
        #1;
        it  = sb.pop_front();
        obs = {gate_req, hw_en, gated};
        total++;
        assert (obs === it.exp) else begin
            bad++;
            $error("FAIL %s observed={req,en,gated}=%b expected=%b", it.tag, obs, it.exp);
        end
    endtask

    initial begin
        rst = 1'b1; auto_en = 1'b1; busy = 1'b1; wake = 1'b0; ack = 1'b0; thresh = 8'd4;
        cyc(1'b1, 1'b0, 1'b0, E_RUN, "reset");
        cyc(1'b1, 1'b0, 1'b0, E_RUN, "reset_hold");
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, E_RUN, "busy_run");

        // thresh=4: gate_req rises on the 5th edge after busy falls; stray ack ignored while counting
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "cnt1");
        cyc(1'b0, 1'b0, 1'b1, E_RUN, "cnt2_ack_ignored");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "cnt3");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "cnt4");
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "req_rise");
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "req_wait1");
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "req_wait2");
        cyc(1'b0, 1'b0, 1'b1, E_GAT, "gated_after_ack");
        cyc(1'b0, 1'b0, 1'b1, E_GAT, "gated_ack_ignored");
        cyc(1'b0, 1'b0, 1'b0, E_GAT, "gated_hold");

        // one-cycle wake pulse, WAKE_CYC=2, then a full idle count before the next request
        cyc(1'b0, 1'b1, 1'b0, E_RUN, "wake_en_high");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "wake_cyc1");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "wake_to_run");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "post_wake_cnt1");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "post_wake_cnt2");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "post_wake_cnt3");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "post_wake_cnt4");
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "post_wake_req");

        // abort in REQ: busy wins over a simultaneous ack
        cyc(1'b1, 1'b0, 1'b1, E_RUN, "req_abort_busy");
        cyc(1'b1, 1'b0, 1'b0, E_RUN, "abort_hold");

        // auto_en dropped at cnt=3 with thresh=8; next idle period restarts from 1
        thresh = 8'd8;
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "a_cnt1");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "a_cnt2");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "a_cnt3");
        auto_en = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "auto_off_run");
        auto_en = 1'b1;
        for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b0, E_RUN, "restart_cnt");
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "restart_req");
        cyc(1'b0, 1'b1, 1'b0, E_RUN, "req_abort_wake");

        // threshold lowered mid-count applies on the next compare
        cyc(1'b1, 1'b0, 1'b0, E_RUN, "t_busy");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "t_cnt1");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "t_cnt2");
        thresh = 8'd2;
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "thresh_lowered_req");
        cyc(1'b1, 1'b0, 1'b0, E_RUN, "t_abort");

        // threshold changed to 0 mid-count -> RUN, then no gating for 1000 idle cycles
        thresh = 8'd4;
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "z_cnt1");
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "z_cnt2");
        thresh = 8'd0;
        for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b0, 1'b0, E_RUN, "thresh0_idle");
        thresh = 8'd1;
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "t1_cnt1");
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "t1_req");

        // reset while GATED forces the enable back on
        cyc(1'b0, 1'b0, 1'b1, E_GAT, "gate_before_rst");
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "rst_in_gated");
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, E_RUN, "after_rst");

        // reset while REQ
        cyc(1'b0, 1'b0, 1'b0, E_RUN, "r_cnt1");
        cyc(1'b0, 1'b0, 1'b0, E_REQ, "r_req");
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, E_RUN, "rst_in_req");
        rst = 1'b0;

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
